// File: rtl/lstm_seq_ctrl.sv
// Sequencer for one LSTM layer: feeds {h(t-1), x(t)} and c(t-1) to the cells, captures c/h after
// CELL_LAT cycles, returns h(t) downstream and arbitrates the weight-write pulse. Option: LSTM_STATE_CLIP_EN.
module lstm_seq_ctrl #(
    parameter int                       WIDTH    = 32,
    parameter int                       NUM      = 68,
    parameter int                       NUM_LSTM = 8,
    parameter int                       CELL_LAT = 2,
    parameter logic signed [WIDTH-1:0]  CLIP_MAX = 32'sh04000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_x_valid,
    output logic                             o_x_ready,
    input  logic [NUM*WIDTH-1:0]             i_x,
    input  logic                             i_first,
    input  logic                             i_last,
    output logic [(NUM+NUM_LSTM)*WIDTH-1:0]  o_cell_x,
    output logic [NUM_LSTM*WIDTH-1:0]        o_prev_state,
    input  logic [NUM_LSTM*WIDTH-1:0]        i_cell_c,
    input  logic [NUM_LSTM*WIDTH-1:0]        i_cell_h,
    output logic                             o_h_valid,
    input  logic                             i_h_ready,
    output logic [NUM_LSTM*WIDTH-1:0]        o_h,
    output logic [NUM_LSTM*WIDTH-1:0]        o_c,
    output logic                             o_h_last,
    output logic [15:0]                      o_step,
    input  logic                             i_wupd_req,
    output logic                             o_cell_wr,
    output logic                             o_busy
);

`ifdef LSTM_STATE_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic [3:0] CNT_INIT = 4'(CELL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EVAL, OUT, WUPD} state_t;

    state_t                      state_r;
    logic [NUM*WIDTH-1:0]        x_r;
    logic [NUM_LSTM*WIDTH-1:0]   h_r;
    logic [NUM_LSTM*WIDTH-1:0]   c_r;
    logic                        last_r;
    logic [3:0]                  cnt_r;
    logic [15:0]                 step_r;
    logic                        h_valid_r;
    logic                        h_last_r;
    logic                        cell_wr_r;

    // Saturates every c word to [-CLIP_MAX, CLIP_MAX] when clipping is built in; h is never clipped.
    function automatic logic [NUM_LSTM*WIDTH-1:0] capture_c(input logic [NUM_LSTM*WIDTH-1:0] v);
        logic [NUM_LSTM*WIDTH-1:0] r;
        logic signed [WIDTH-1:0]   w;
        r = v;
        for (int k = 0; k < NUM_LSTM; k++) begin
            w = $signed(v[k*WIDTH +: WIDTH]);
            if (CLIP_EN && (w > CLIP_MAX)) begin
                r[k*WIDTH +: WIDTH] = CLIP_MAX;
            end else if (CLIP_EN && (w < -CLIP_MAX)) begin
                r[k*WIDTH +: WIDTH] = -CLIP_MAX;
            end else begin
                r[k*WIDTH +: WIDTH] = v[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    assign o_x_ready    = rst && (state_r == IDLE) && !i_wupd_req;
    assign o_busy       = (state_r != IDLE);
    assign o_cell_x     = {h_r, x_r};
    assign o_prev_state = c_r;
    assign o_h          = h_r;
    assign o_c          = c_r;
    assign o_h_valid    = h_valid_r;
    assign o_h_last     = h_last_r;
    assign o_step       = step_r;
    assign o_cell_wr    = cell_wr_r;

    // Step sequencer; weight writes are only granted from IDLE so cells see fixed weights while evaluating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            x_r       <= '0;
            h_r       <= '0;
            c_r       <= '0;
            last_r    <= 1'b0;
            cnt_r     <= 4'd0;
            step_r    <= 16'd0;
            h_valid_r <= 1'b0;
            h_last_r  <= 1'b0;
            cell_wr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    h_valid_r <= 1'b0;
                    h_last_r  <= 1'b0;
                    if (i_wupd_req) begin
                        cell_wr_r <= 1'b1;
                        state_r   <= WUPD;
                    end else if (i_x_valid) begin
                        cell_wr_r <= 1'b0;
                        x_r       <= i_x;
                        last_r    <= i_last;
                        cnt_r     <= CNT_INIT;
                        state_r   <= EVAL;
                        if (i_first) begin
                            h_r    <= '0;
                            c_r    <= '0;
                            step_r <= 16'd0;
                        end else begin
                            step_r <= step_r + 16'd1;
                        end
                    end else begin
                        cell_wr_r <= 1'b0;
                    end
                end
                EVAL: begin
                    cell_wr_r <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        h_r       <= i_cell_h;
                        c_r       <= capture_c(i_cell_c);
                        h_valid_r <= 1'b1;
                        h_last_r  <= last_r;
                        state_r   <= OUT;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                OUT: begin
                    cell_wr_r <= 1'b0;
                    if (i_h_ready) begin
                        h_valid_r <= 1'b0;
                        h_last_r  <= 1'b0;
                        state_r   <= IDLE;
                        if (last_r) begin
                            h_r <= '0;
                            c_r <= '0;
                        end else begin
                            h_r <= h_r;
                        end
                    end else begin
                        h_valid_r <= 1'b1;
                    end
                end
                WUPD: begin
                    cell_wr_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    h_valid_r <= 1'b0;
                    h_last_r  <= 1'b0;
                    cell_wr_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl: a stand-in cell array plus a step-level reference model.
module tb_lstm_seq_ctrl;
    localparam int WIDTH    = 32;
    localparam int NUM      = 68;
    localparam int NUM_LSTM = 8;
    localparam int CELL_LAT = 2;
    localparam int HW       = NUM_LSTM * WIDTH;
    localparam int XW       = NUM * WIDTH;
    localparam int CW       = (NUM + NUM_LSTM) * WIDTH;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_x_valid, o_x_ready, i_first, i_last;
    logic [XW-1:0]  i_x;
    logic [CW-1:0]  o_cell_x;
    logic [HW-1:0]  o_prev_state, i_cell_c, i_cell_h, o_h, o_c;
    logic           o_h_valid, i_h_ready, o_h_last, i_wupd_req, o_cell_wr, o_busy;
    logic [15:0]    o_step;

    int checks = 0;
    int errors = 0;

    logic           force_en  = 1'b0;
    logic [31:0]    force_val = 32'd0;

    // reference model state
    logic [31:0]    mh [NUM_LSTM];
    logic [31:0]    mc [NUM_LSTM];
    logic [15:0]    mstep;
    logic           mlast;
    logic [15:0]    got_step;
    logic           got_last;
    logic [HW-1:0]  got_c;
    logic [HW-1:0]  got_h_after;

    lstm_seq_ctrl #(.WIDTH(WIDTH), .NUM(NUM), .NUM_LSTM(NUM_LSTM), .CELL_LAT(CELL_LAT)) dut (
        .clk(clk), .rst(rst), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x(i_x),
        .i_first(i_first), .i_last(i_last), .o_cell_x(o_cell_x), .o_prev_state(o_prev_state),
        .i_cell_c(i_cell_c), .i_cell_h(i_cell_h), .o_h_valid(o_h_valid), .i_h_ready(i_h_ready),
        .o_h(o_h), .o_c(o_c), .o_h_last(o_h_last), .o_step(o_step), .i_wupd_req(i_wupd_req),
        .o_cell_wr(o_cell_wr), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Stand-in cells: c = c_prev + x_k + k<<20 (or a forced value), h = (c >>> 2) + h_prev.
    always_comb begin
        i_cell_c = '0;
        i_cell_h = '0;
        for (int k = 0; k < NUM_LSTM; k++) begin
            i_cell_c[k*WIDTH +: WIDTH] = force_en ? force_val :
                o_prev_state[k*WIDTH +: WIDTH] + o_cell_x[k*WIDTH +: WIDTH] + (32'(k) << 20);
            i_cell_h[k*WIDTH +: WIDTH] = 32'($signed(i_cell_c[k*WIDTH +: WIDTH]) >>> 2)
                                       + o_cell_x[XW + k*WIDTH +: WIDTH];
        end
    end

    task automatic chk_w(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] clip_model(input logic [31:0] v);
`ifdef LSTM_STATE_CLIP_EN
        if ($signed(v) > $signed(32'sh04000000)) return 32'sh04000000;
        if ($signed(v) < $signed(32'shFC000000)) return 32'shFC000000;
`endif
        return v;
    endfunction

    function automatic logic [HW-1:0] pack_h();
        logic [HW-1:0] r;
        for (int k = 0; k < NUM_LSTM; k++) r[k*WIDTH +: WIDTH] = mh[k];
        return r;
    endfunction

    function automatic logic [HW-1:0] pack_c();
        logic [HW-1:0] r;
        for (int k = 0; k < NUM_LSTM; k++) r[k*WIDTH +: WIDTH] = mc[k];
        return r;
    endfunction

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] r;
        for (int i = 0; i < NUM; i++) r[i*WIDTH +: WIDTH] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NUM_LSTM; k++) begin
            mh[k] = 32'd0;
            mc[k] = 32'd0;
        end
    endtask

    task automatic model_step(input logic [XW-1:0] x, input logic first);
        logic [31:0] c;
        if (first) begin
            model_clear();
            mstep = 16'd0;
        end else begin
            mstep = mstep + 16'd1;
        end
        for (int k = 0; k < NUM_LSTM; k++) begin
            c     = force_en ? force_val : mc[k] + x[k*WIDTH +: WIDTH] + (32'(k) << 20);
            mh[k] = 32'($signed(c) >>> 2) + mh[k];
            mc[k] = clip_model(c);
        end
    endtask

    task automatic do_step(input logic [XW-1:0] x, input logic first, input logic last,
                           input int hold, input logic wupd_in_eval);
        int n;
        int lat;
        logic wr_seen;
        logic [HW-1:0] h0;
        i_x = x; i_first = first; i_last = last; i_x_valid = 1'b1;
        n = 0;
        while (!o_x_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk_i("x_ready_wait", int'(n < 20), 1);
        @(posedge clk); #1;
        i_x_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
        model_step(x, first);
        mlast = last;
        if (wupd_in_eval) i_wupd_req = 1'b1;
        wr_seen = 1'b0;
        lat = 1;
        while (!o_h_valid && lat < 40) begin
            if (o_cell_wr) wr_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        chk_i("latency", lat, CELL_LAT + 1);
        chk_w("h_out", o_h, pack_h());
        chk_w("c_out", o_c, pack_c());
        chk_i("step", int'(o_step), int'(mstep));
        chk_i("h_last", int'(o_h_last), int'(mlast));
        got_step = o_step; got_last = o_h_last; got_c = o_c;
        h0 = o_h;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (o_cell_wr) wr_seen = 1'b1;
            chk_i("hold_valid", int'(o_h_valid), 1);
            chk_i("hold_x_ready", int'(o_x_ready), 0);
            chk_w("hold_h_stable", o_h, h0);
        end
        i_h_ready = 1'b1;
        @(posedge clk); #1;
        i_h_ready = 1'b0;
        chk_i("valid_drop", int'(o_h_valid), 0);
        if (mlast) model_clear();
        chk_w("h_after", o_h, pack_h());
        chk_w("c_after", o_c, pack_c());
        got_h_after = o_h;
        if (wupd_in_eval) begin
            chk_i("no_wr_in_eval_out", int'(wr_seen), 0);
            @(posedge clk); #1;
            chk_i("wr_after_out", int'(o_cell_wr), 1);
            i_wupd_req = 1'b0;
            @(posedge clk); #1;
            chk_i("wr_one_cycle", int'(o_cell_wr), 0);
        end
    endtask

    task automatic wupd_pulse();
        int n;
        i_wupd_req = 1'b1;
        n = 0;
        while (!o_cell_wr && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk_i("wupd_seen", int'(o_cell_wr), 1);
        i_wupd_req = 1'b0;
        @(posedge clk); #1;
        chk_i("wupd_one_cycle", int'(o_cell_wr), 0);
        chk_w("wupd_h_untouched", o_h, pack_h());
    endtask

    typedef struct {
        logic        first;
        logic        last;
        int          hold;
        logic        wupd;
        logic [15:0] exp_step;
        logic        exp_last;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{first: 1'b1, last: 1'b0, hold: 0, wupd: 1'b0, exp_step: 16'd0, exp_last: 1'b0};
        tbl[1] = '{first: 1'b0, last: 1'b0, hold: 5, wupd: 1'b0, exp_step: 16'd1, exp_last: 1'b0};
        tbl[2] = '{first: 1'b0, last: 1'b1, hold: 0, wupd: 1'b0, exp_step: 16'd2, exp_last: 1'b1};
        tbl[3] = '{first: 1'b0, last: 1'b0, hold: 0, wupd: 1'b0, exp_step: 16'd3, exp_last: 1'b0};
        tbl[4] = '{first: 1'b1, last: 1'b0, hold: 1, wupd: 1'b1, exp_step: 16'd0, exp_last: 1'b0};
        tbl[5] = '{first: 1'b0, last: 1'b1, hold: 2, wupd: 1'b0, exp_step: 16'd1, exp_last: 1'b1};

        rst = 1'b0; i_x_valid = 1'b0; i_x = '0; i_first = 1'b0; i_last = 1'b0;
        i_h_ready = 1'b0; i_wupd_req = 1'b0;
        model_clear(); mstep = 16'd0; mlast = 1'b0;
        @(posedge clk); #1;
        chk_i("rst_x_ready_low", int'(o_x_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_i("rst_h_valid", int'(o_h_valid), 0);
        chk_i("rst_x_ready", int'(o_x_ready), 1);
        chk_i("rst_step", int'(o_step), 0);
        chk_i("rst_busy", int'(o_busy), 0);
        chk_i("rst_cell_wr", int'(o_cell_wr), 0);
        chk_w("rst_h", o_h, '0);
        chk_w("rst_c", o_c, '0);
        @(posedge clk); #1;

        // Directed table: sequence framing, hold in OUT, missing first, wupd during EVAL.
        for (int i = 0; i < 6; i++) begin
            do_step(rand_x(), tbl[i].first, tbl[i].last, tbl[i].hold, tbl[i].wupd);
            chk_i("tbl_step", int'(got_step), int'(tbl[i].exp_step));
            chk_i("tbl_last", int'(got_last), int'(tbl[i].exp_last));
            if (tbl[i].exp_last) chk_w("tbl_state_cleared", got_h_after, '0);
        end

        // wupd and x_valid in the same IDLE cycle: wupd wins, x is taken afterwards.
        begin
            logic [XW-1:0] xs;
            xs = rand_x();
            i_x = xs; i_first = 1'b1; i_x_valid = 1'b1; i_wupd_req = 1'b1;
            #1;
            chk_i("wupd_blocks_ready", int'(o_x_ready), 0);
            @(posedge clk); #1;
            chk_i("wupd_wins", int'(o_cell_wr), 1);
            chk_i("wupd_busy", int'(o_busy), 1);
            i_wupd_req = 1'b0;
            @(posedge clk); #1;
            chk_i("wupd_pulse_end", int'(o_cell_wr), 0);
            chk_i("wupd_x_pending", int'(o_x_ready), 1);
            do_step(xs, 1'b1, 1'b0, 0, 1'b0);
            chk_i("after_wupd_step", int'(got_step), 0);
        end

        // Randomized steps and weight updates against the model.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) wupd_pulse();
            do_step(rand_x(), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
        end

        // Reset asserted mid-EVAL discards the step.
        i_x = rand_x(); i_first = 1'b0; i_x_valid = 1'b1;
        @(posedge clk); #1;
        i_x_valid = 1'b0;
        chk_i("mid_eval_busy", int'(o_busy), 1);
        #2 rst = 1'b0;
        #1;
        chk_i("mr_busy", int'(o_busy), 0);
        chk_i("mr_valid", int'(o_h_valid), 0);
        chk_i("mr_x_ready", int'(o_x_ready), 0);
        chk_i("mr_step", int'(o_step), 0);
        chk_w("mr_h", o_h, '0);
        chk_w("mr_c", o_c, '0);
        chk_w("mr_cell_x_h", o_cell_x[CW-1 -: HW], '0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear(); mstep = 16'd0;
        #1;
        chk_i("mr_release_ready", int'(o_x_ready), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_i("mr_no_stale_valid", int'(o_h_valid), 0);
        end
        do_step(rand_x(), 1'b0, 1'b0, 0, 1'b0);
        chk_i("mr_step_after", int'(got_step), 1);

        // Clipping of captured c (h is passed through untouched).
        force_en = 1'b1;
        force_val = 32'sh06000000;
        do_step(rand_x(), 1'b1, 1'b0, 0, 1'b0);
`ifdef LSTM_STATE_CLIP_EN
        chk_w("clip_pos", got_c[WIDTH-1:0], HW'(32'h04000000));
`else
        chk_w("noclip_pos", got_c[WIDTH-1:0], HW'(32'h06000000));
`endif
        force_val = 32'shFA000000;
        do_step(rand_x(), 1'b1, 1'b1, 0, 1'b0);
`ifdef LSTM_STATE_CLIP_EN
        chk_w("clip_neg", got_c[WIDTH-1:0], HW'(32'hFC000000));
`else
        chk_w("noclip_neg", got_c[WIDTH-1:0], HW'(32'hFA000000));
`endif
        force_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
